tdm_link: RTL and testbench
===========================

// Module: tdm_link
// PURPOSE
//  Parametrised TDM serial link: TX serialises one DW-bit word per timeslot plus a parity bit;
//  RX realigns on sync, deserialises, checks parity, counts errors and reports lock loss.
//  Serial pins are exposed on both sides so the bench can loop them back or inject faults.
// PARAMETERS
//  DW     8   data bits per slot
//  NSLOT  32  slots per frame (>=2)
//  TSW    $clog2(NSLOT)  slot index width (derived, not overridden)
//  ERRW   8   parity-error counter width
// PORTS
//  clk        in   1     single clock, all logic on rising edge
//  reset      in   1     asynchronous, active-high; clears all state
//  par_odd    in   1     0=even, 1=odd parity; quasi-static, change only while in reset
//  data_in    in   DW    TX word, sampled on last bit cycle of each slot
//  load_req   out  1     high on last bit cycle of each slot (data_in sampled this edge)
//  ts_in      out  TSW   slot currently on the TX line
//  sdata      out  1     TX serial data
//  sync       out  1     TX frame sync, high during bit 0 of slot 0
//  sdata_rx   in   1     RX serial data
//  sync_rx    in   1     RX frame sync
//  data_out   out  DW    last received word
//  ts_out     out  TSW   slot of data_out
//  out_valid  out  1     1-cycle strobe: data_out/ts_out/par_err updated
//  par_err    out  1     parity result of data_out (1 = mismatch)
//  err_cnt    out  ERRW  saturating parity-error count
//  err_clr    in   1     synchronous clear of err_cnt
//  sync_lost  out  1     high while RX is in HUNT
// BEHAVIOUR
//  Slot = DW+1 bit cycles: DW data bits MSB first, then parity bit. Frame = NSLOT slots.
//  TX: bit counter 0..DW, slot counter 0..NSLOT-1, wrap to 0. Reset: shreg=0, counters=0,
//   sdata=0, sync=0 (asserts from first cycle after release), ts_in=0, load_req=0.
//   First slot after reset transmits word 0 with correct parity (par_odd ? 1 : 0).
//   Word sampled at end of slot k is transmitted in slot k+1 mod NSLOT.
//   Parity bit = ^word ^ par_odd, computed on the loaded word.
//  RX states: HUNT (reset state), LOCK.
//   HUNT: ignore sdata_rx until sync_rx=1; that cycle is bit 0 of slot 0 (sampled), go LOCK.
//   LOCK: shift DW bits, sample parity bit; next cycle out_valid=1, data_out, ts_out, par_err.
//   RX latency: bit 0 of a slot at cycle t -> out_valid at cycle t+DW+1.
//   At expected frame start (slot 0, bit 0) sync_rx must be 1, else -> HUNT, that slot dropped.
//   sync_rx=1 at any other point in LOCK: abandon partial slot (no out_valid), realign to
//    slot 0 bit 0, stay LOCK.
//   sync_lost = (state==HUNT). A slot whose parity bit completes is always reported, even if
//    sync fails on the following cycle.
//  err_cnt: +1 on out_valid&par_err, saturates at all-ones; err_clr wins over hold;
//   err_clr and new error in same cycle -> 1.
//  Reset values RX: data_out=0, ts_out=0, out_valid=0, par_err=0, err_cnt=0, sync_lost=1.
//  Reset asserted mid-frame: both sides return to reset state immediately; no partial output.
// STRUCTURE
//  Package tdm_pkg: rx_state_t {HUNT, LOCK}; parity function par_calc(word, odd).
//  Sub-module tdm_link_rx (RX FSM, deserialiser, error counter); TX inline in tdm_link.
// TESTING (DW=8, NSLOT=4, loopback unless noted)
//  1 reset, par_odd=0, data_in 8'hA5,3C,FF,00 per load_req -> RX yields same words on
//    ts_out 1,2,3,0, par_err=0, lock within first frame, sync_lost drops on first sync.
//  2 par_odd=1, data_in 8'h00 -> TX parity bit=1, RX par_err=0; force parity bit flipped
//    -> par_err=1, err_cnt=1.
//  3 inject 300 parity errors -> err_cnt=255 held; err_clr with error same cycle -> 1.
//  4 suppress one sync_rx at frame start -> sync_lost=1, no out_valid until next sync,
//    then correct data resumes from slot 0.
//  5 pulse sync_rx at slot 2 bit 4 -> slot-2 word dropped, realigned, next out_valid ts_out=0.
//  6 assert reset mid-slot -> all outputs at reset values same cycle; sync_lost=1.

Source files
------------

// File: rtl/tdm_pkg.sv
//==============================================================================
// Module  : tdm_pkg
// Brief   : Shared types and the parity helper for the TDM serial link.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

package tdm_pkg;

    localparam int MAX_DW = 64;

    typedef enum logic [0:0] {
        HUNT = 1'b0,
        LOCK = 1'b1
    } rx_state_t;

    // Words narrower than MAX_DW are zero-extended, which leaves parity unchanged
    function automatic logic par_calc(input logic [MAX_DW-1:0] word, input logic odd);
        return (^word) ^ odd;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tdm_link_if.sv
//==============================================================================
// Module  : tdm_link_if
// Brief   : TX, RX and status signal bundle of the TDM link.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

interface tdm_link_if #(
    parameter int DW    = 8,
    parameter int NSLOT = 32,
    parameter int ERRW  = 8
);
    localparam int TSW = $clog2(NSLOT);

    logic            par_odd;
    logic [DW-1:0]   data_in;
    logic            load_req;
    logic [TSW-1:0]  ts_in;
    logic            sdata;
    logic            sync;
    logic            sdata_rx;
    logic            sync_rx;
    logic [DW-1:0]   data_out;
    logic [TSW-1:0]  ts_out;
    logic            out_valid;
    logic            par_err;
    logic [ERRW-1:0] err_cnt;
    logic            err_clr;
    logic            sync_lost;

    modport master (
        input  par_odd, data_in, sdata_rx, sync_rx, err_clr,
        output load_req, ts_in, sdata, sync, data_out, ts_out,
               out_valid, par_err, err_cnt, sync_lost
    );

    modport slave (
        output par_odd, data_in, sdata_rx, sync_rx, err_clr,
        input  load_req, ts_in, sdata, sync, data_out, ts_out,
               out_valid, par_err, err_cnt, sync_lost
    );

endinterface

`default_nettype wire

// File: rtl/tdm_link_rx.sv
//==============================================================================
// Module  : tdm_link_rx
// Brief   : RX frame aligner, deserialiser, parity checker and error counter.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module tdm_link_rx
    import tdm_pkg::*;
#(
    parameter int DW    = 8,
    parameter int NSLOT = 32,
    parameter int ERRW  = 8
) (
    input  wire                      clk,
    input  wire                      reset,
    input  wire                      par_odd_i,
    input  wire                      sdata_i,
    input  wire                      sync_i,
    input  wire                      err_clr_i,
    output logic [DW-1:0]            data_o,
    output logic [$clog2(NSLOT)-1:0] ts_o,
    output logic                     valid_o,
    output logic                     par_err_o,
    output logic [ERRW-1:0]          err_cnt_o,
    output logic                     sync_lost_o
);

    localparam int TSW = $clog2(NSLOT);
    localparam int BW  = $clog2(DW + 1);
    localparam logic [BW-1:0]  C_LAST_BIT  = BW'(DW);
    localparam logic [TSW-1:0] C_LAST_SLOT = TSW'(NSLOT - 1);

    rx_state_t       state_q;
    logic [BW-1:0]   bit_q;
    logic [TSW-1:0]  slot_q;
    logic [DW-1:0]   shreg_q;
    logic [DW-1:0]   shreg_d;
    logic            frame_start;
    logic [DW-1:0]   data_q;
    logic [TSW-1:0]  ts_q;
    logic            valid_q;
    logic            perr_q;
    logic [ERRW-1:0] err_q;

    always_comb begin
        frame_start = (bit_q == '0) && (slot_q == '0);
        shreg_d     = {shreg_q[DW-2:0], sdata_i};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= HUNT;
            bit_q   <= '0;
            slot_q  <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            ts_q    <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                HUNT: begin
                    if (sync_i) begin
                        state_q <= LOCK;
                        shreg_q <= shreg_d;
                        bit_q   <= BW'(1);
                        slot_q  <= '0;
                    end
                end
                LOCK: begin
                    if (frame_start && !sync_i) begin
                        state_q <= HUNT;
                        bit_q   <= '0;
                        slot_q  <= '0;
                    end else if (sync_i) begin
                        // Sync anywhere re-anchors to bit 0 of slot 0; a partial slot is discarded
                        shreg_q <= shreg_d;
                        bit_q   <= BW'(1);
                        slot_q  <= '0;
                    end else if (bit_q == C_LAST_BIT) begin
                        valid_q <= 1'b1;
                        data_q  <= shreg_q;
                        ts_q    <= slot_q;
                        perr_q  <= par_calc(MAX_DW'(shreg_q), par_odd_i) ^ sdata_i;
                        bit_q   <= '0;
                        slot_q  <= (slot_q == C_LAST_SLOT) ? '0 : slot_q + TSW'(1);
                    end else begin
                        shreg_q <= shreg_d;
                        bit_q   <= bit_q + BW'(1);
                    end
                end
                default: state_q <= HUNT;
            endcase
        end
    end

    // Counts errors already visible on the outputs, so a clear in that cycle leaves exactly one
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= '0;
        end else if (err_clr_i) begin
            err_q <= ERRW'(valid_q & perr_q);
        end else if (valid_q && perr_q && (err_q != '1)) begin
            err_q <= err_q + ERRW'(1);
        end
    end

    assign data_o      = data_q;
    assign ts_o        = ts_q;
    assign valid_o     = valid_q;
    assign par_err_o   = perr_q;
    assign err_cnt_o   = err_q;
    assign sync_lost_o = (state_q == HUNT);

endmodule

`default_nettype wire

// File: rtl/tdm_link.sv
//==============================================================================
// Module  : tdm_link
// Brief   : TDM serial link top: inline TX serialiser plus the RX sub-block.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module tdm_link
    import tdm_pkg::*;
#(
    parameter int DW    = 8,
    parameter int NSLOT = 32,
    parameter int ERRW  = 8
) (
    input  wire         clk,
    input  wire         reset,
    tdm_link_if.master  link
);

    localparam int TSW = $clog2(NSLOT);
    localparam int BW  = $clog2(DW + 1);
    localparam logic [BW-1:0]  C_LAST_BIT  = BW'(DW);
    localparam logic [TSW-1:0] C_LAST_SLOT = TSW'(NSLOT - 1);

    logic [BW-1:0]  tx_bit_q;
    logic [TSW-1:0] tx_slot_q;
    logic [DW-1:0]  tx_word_q;
    logic [DW-1:0]  tx_word_d;
    logic [DW-1:0]  tx_shift;
    logic           tx_sdata_d;
    logic           tx_sdata_q;
    logic           tx_sync_q;
    logic           tx_load_q;
    logic [TSW-1:0] tx_ts_q;

    // Counters name the bit about to be driven; every TX output is registered one edge later
    always_comb begin
        tx_word_d  = tx_load_q ? link.data_in : tx_word_q;
        tx_shift   = tx_word_d << tx_bit_q;
        tx_sdata_d = (tx_bit_q == C_LAST_BIT) ? par_calc(MAX_DW'(tx_word_d), link.par_odd)
                                              : tx_shift[DW-1];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_bit_q   <= '0;
            tx_slot_q  <= '0;
            tx_word_q  <= '0;
            tx_sdata_q <= 1'b0;
            tx_sync_q  <= 1'b0;
            tx_load_q  <= 1'b0;
            tx_ts_q    <= '0;
        end else begin
            tx_word_q  <= tx_word_d;
            tx_sdata_q <= tx_sdata_d;
            tx_sync_q  <= (tx_bit_q == '0) && (tx_slot_q == '0);
            tx_load_q  <= (tx_bit_q == C_LAST_BIT);
            tx_ts_q    <= tx_slot_q;
            if (tx_bit_q == C_LAST_BIT) begin
                tx_bit_q  <= '0;
                tx_slot_q <= (tx_slot_q == C_LAST_SLOT) ? '0 : tx_slot_q + TSW'(1);
            end else begin
                tx_bit_q  <= tx_bit_q + BW'(1);
            end
        end
    end

    assign link.sdata    = tx_sdata_q;
    assign link.sync     = tx_sync_q;
    assign link.load_req = tx_load_q;
    assign link.ts_in    = tx_ts_q;

    tdm_link_rx #(
        .DW    (DW),
        .NSLOT (NSLOT),
        .ERRW  (ERRW)
    ) u_rx (
        .clk         (clk),
        .reset       (reset),
        .par_odd_i   (link.par_odd),
        .sdata_i     (link.sdata_rx),
        .sync_i      (link.sync_rx),
        .err_clr_i   (link.err_clr),
        .data_o      (link.data_out),
        .ts_o        (link.ts_out),
        .valid_o     (link.out_valid),
        .par_err_o   (link.par_err),
        .err_cnt_o   (link.err_cnt),
        .sync_lost_o (link.sync_lost)
    );

endmodule

`default_nettype wire

// File: tb/tb_tdm_link.sv
//==============================================================================
// Module  : tb_tdm_link
// Brief   : Loopback bench for tdm_link with parity and sync fault injection.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_tdm_link;

    localparam int DW    = 8;
    localparam int NSLOT = 4;
    localparam int ERRW  = 8;
    localparam int TSW   = $clog2(NSLOT);
    localparam int SLOT  = DW + 1;
    localparam int FRAME = SLOT * NSLOT;

    typedef struct {
        logic [TSW-1:0] ts;
        logic [DW-1:0]  data;
        logic           perr;
        logic           chk;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    int errors = 0;
    int checks = 0;

    exp_t          sb[$];
    logic [DW-1:0] feed_q[$];

    logic sb_en      = 1'b1;
    logic flip_req   = 1'b0;
    logic flip_cur   = 1'b0;
    logic flip_pend  = 1'b0;
    logic sup_sync   = 1'b0;
    logic force_sync = 1'b0;

    int            cyc;
    int            tx_slot;
    logic          ld_prev;
    logic [DW-1:0] cur_word;
    logic [DW-1:0] next_word;

    tdm_link_if #(.DW(DW), .NSLOT(NSLOT), .ERRW(ERRW)) link ();

    tdm_link #(.DW(DW), .NSLOT(NSLOT), .ERRW(ERRW)) dut (
        .clk   (clk),
        .reset (reset),
        .link  (link)
    );

    always #5 clk = ~clk;

    // Loopback with optional parity-bit corruption and sync suppression/forcing
    assign link.sdata_rx = link.sdata ^ (link.load_req & flip_cur);
    assign link.sync_rx  = (link.sync & ~sup_sync) | force_sync;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_sync();
        int n = 0;
        do begin @(negedge clk); n++; end while (!link.sync && n < 200);
        check("wait_sync", 32'(link.sync), 32'(1));
    endtask

    task automatic wait_load();
        int n = 0;
        do begin @(negedge clk); n++; end while (!link.load_req && n < 60);
        check("wait_load", 32'(link.load_req), 32'(1));
    endtask

    task automatic wait_valid();
        int n = 0;
        do begin @(negedge clk); n++; end while (!link.out_valid && n < 60);
        check("wait_valid", 32'(link.out_valid), 32'(1));
    endtask

    task automatic check_reset_outputs();
        check("rst_sdata",     32'(link.sdata),     32'(0));
        check("rst_sync",      32'(link.sync),      32'(0));
        check("rst_ts_in",     32'(link.ts_in),     32'(0));
        check("rst_load_req",  32'(link.load_req),  32'(0));
        check("rst_data_out",  32'(link.data_out),  32'(0));
        check("rst_ts_out",    32'(link.ts_out),    32'(0));
        check("rst_out_valid", 32'(link.out_valid), 32'(0));
        check("rst_par_err",   32'(link.par_err),   32'(0));
        check("rst_err_cnt",   32'(link.err_cnt),   32'(0));
        check("rst_sync_lost", 32'(link.sync_lost), 32'(1));
    endtask

    // The first slot after reset always carries word 0
    task automatic release_reset();
        sb.delete();
        sb.push_back('{ts: '0, data: '0, perr: 1'b0, chk: 1'b1});
        @(negedge clk);
        #2 reset = 1'b0;
    endtask

    // TX model: frame timing, slot numbering and parity bit; feeds words and fills the scoreboard
    always @(negedge clk) begin
        logic [DW-1:0] w;
        logic          exp_load;
        logic          exp_sync;
        if (reset) begin
            cyc          = 0;
            tx_slot      = 0;
            cur_word     = '0;
            next_word    = '0;
            flip_cur     = 1'b0;
            flip_pend    = 1'b0;
            ld_prev      = 1'b0;
            link.data_in = '0;
        end else begin
            cyc++;
            if (ld_prev) begin
                cur_word = next_word;
                flip_cur = flip_pend;
                tx_slot  = (tx_slot + 1) % NSLOT;
            end
            ld_prev  = 1'b0;
            exp_load = ((cyc - 1) % SLOT) == DW;
            exp_sync = ((cyc - 1) % FRAME) == 0;
            if (exp_load || link.load_req)
                check("tx_load_req", 32'(link.load_req), 32'(exp_load));
            if (exp_sync || link.sync)
                check("tx_sync", 32'(link.sync), 32'(exp_sync));
            if (exp_load) begin
                check("tx_ts_in", 32'(link.ts_in), 32'(tx_slot));
                check("tx_parity", 32'(link.sdata), 32'((^cur_word) ^ link.par_odd));
                w            = (feed_q.size() > 0) ? feed_q.pop_front() : DW'($urandom);
                link.data_in = w;
                next_word    = w;
                flip_pend    = flip_req;
                ld_prev      = 1'b1;
                if (sb_en)
                    sb.push_back('{ts: TSW'((tx_slot + 1) % NSLOT), data: w,
                                   perr: flip_req, chk: 1'b1});
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!reset && link.out_valid) begin
            if (sb.size() == 0) begin
                check("rx_unexpected_valid", 32'(link.out_valid), 32'(0));
            end else begin
                e = sb.pop_front();
                check("rx_ts_out", 32'(link.ts_out), 32'(e.ts));
                if (e.chk) begin
                    check("rx_data_out", 32'(link.data_out), 32'(e.data));
                    check("rx_par_err",  32'(link.par_err),  32'(e.perr));
                end
            end
        end
    end

    initial begin
        link.par_odd = 1'b0;
        link.err_clr = 1'b0;
        step(2);
        check_reset_outputs();

        // Even parity loopback of a directed word sequence
        feed_q = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
        release_reset();
        step(1);
        check("t1_sync_lost_first", 32'(link.sync_lost), 32'(1));
        step(1);
        check("t1_sync_lost_locked", 32'(link.sync_lost), 32'(0));
        step(3 * FRAME);

        // Missing sync at a frame start drops to HUNT until the next sync
        wait_sync();
        step(30);
        sb_en    = 1'b0;
        sup_sync = 1'b1;
        step(7);
        check("t4_sync_lost_hunt", 32'(link.sync_lost), 32'(1));
        step(3);
        sup_sync = 1'b0;
        step(26);
        sb_en = 1'b1;
        step(6);
        check("t4_sync_lost_before_relock", 32'(link.sync_lost), 32'(1));
        step(1);
        check("t4_sync_lost_relocked", 32'(link.sync_lost), 32'(0));
        step(FRAME);

        // Stray sync at slot 2 bit 4: slot 2 dropped, next report comes out as slot 0
        wait_sync();
        step(2 * SLOT + 4);
        sb.delete();
        sb.push_back('{ts: '0, data: '0, perr: 1'b0, chk: 1'b0});
        sb_en      = 1'b0;
        force_sync = 1'b1;
        step(1);
        force_sync = 1'b0;
        check("t5_sync_lost_stays", 32'(link.sync_lost), 32'(0));
        step(7);
        sb_en = 1'b1;
        step(7);
        check("t5_sync_lost_after_frame", 32'(link.sync_lost), 32'(0));
        step(FRAME);

        // Odd parity, then one corrupted parity bit
        @(negedge clk);
        #2 reset = 1'b1;
        link.par_odd = 1'b1;
        feed_q = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        step(2);
        release_reset();
        step(40);
        wait_load();
        step(1);
        flip_req = 1'b1;
        step(9);
        flip_req = 1'b0;
        check("t2_err_cnt_before", 32'(link.err_cnt), 32'(0));
        step(10);
        check("t2_err_cnt_one", 32'(link.err_cnt), 32'(1));

        // Saturation, clear without error, clear coinciding with an error
        wait_load();
        step(1);
        flip_req = 1'b1;
        step(SLOT * 305);
        check("t3_err_cnt_saturated", 32'(link.err_cnt), 32'(255));
        wait_valid();
        step(2);
        link.err_clr = 1'b1;
        step(1);
        link.err_clr = 1'b0;
        check("t3_err_clr_plain", 32'(link.err_cnt), 32'(0));
        wait_valid();
        link.err_clr = 1'b1;
        step(1);
        link.err_clr = 1'b0;
        check("t3_err_clr_with_error", 32'(link.err_cnt), 32'(1));
        step(1);
        flip_req = 1'b0;
        step(18);
        check("t3_err_cnt_after_tail", 32'(link.err_cnt), 32'(2));

        // Reset asserted mid-slot while a word is being reported
        wait_valid();
        #2 reset = 1'b1;
        #1 check_reset_outputs();
        step(2);
        release_reset();
        step(FRAME + 10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
